// File: rtl/plru_replacement_unit.sv
// rtl/plru_replacement_unit.sv - per-set tree-PLRU replacement engine with invalid-first victim selection
//
// Ports:
//   clk, reset_n            clock (rising edge), synchronous active-low reset
//   flush                   pulse: restart the clearing sweep of all PLRU state
//   busy                    sweep in progress
//   sel_valid/sel_ready     victim request handshake (sel_ready = !busy)
//   sel_set, sel_valids     set index and per-way valid bits of the request
//   victim_valid            one-cycle response pulse, one cycle after acceptance
//   victim_way              chosen way
//   victim_was_invalid      victim picked because that way was invalid
//   touch_valid/set/way     access update (hit or fill)
module plru_replacement_unit #(
    parameter int WAYS       = 4,
    parameter int LOG_WAYS   = 2,
    parameter int SETS       = 64,
    parameter int LOG_SETS   = 6,
    parameter int AUTO_TOUCH = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    output logic                busy,
    input  logic                sel_valid,
    output logic                sel_ready,
    input  logic [LOG_SETS-1:0] sel_set,
    input  logic [WAYS-1:0]     sel_valids,
    output logic                victim_valid,
    output logic [LOG_WAYS-1:0] victim_way,
    output logic                victim_was_invalid,
    input  logic                touch_valid,
    input  logic [LOG_SETS-1:0] touch_set,
    input  logic [LOG_WAYS-1:0] touch_way
);

    // width of an index into the WAYS-1 node bits of one set
    localparam int NW = (WAYS > 2) ? $clog2(WAYS - 1) : 1;
    localparam logic [LOG_SETS-1:0] LAST_SET = LOG_SETS'(SETS - 1);

    typedef enum logic {
        ST_SWEEP,
        ST_IDLE
    } state_t;

    state_t              state_q, state_d;
    logic [LOG_SETS-1:0] cnt_q, cnt_d;

    // heap-ordered node bits per set; cleared by the sweep, so no reset
    logic [WAYS-2:0]     plru [SETS];

    logic                accept;
    logic                touch_en;
    logic [WAYS-2:0]     sel_cur;
    logic                inv_found;
    logic [LOG_WAYS-1:0] inv_way;
    logic [LOG_WAYS-1:0] victim_way_d;

    // Level l of the tree holds nodes (2^l)-1 .. (2^(l+1))-2; the node a way
    // passes through at level l is offset by the way's top l bits, and the
    // way's next bit says which child it descends into.
    function automatic logic [WAYS-2:0] touch_bits(input logic [WAYS-2:0] bits,
                                                   input logic [LOG_WAYS-1:0] way);
        logic [WAYS-2:0]     r;
        logic [LOG_WAYS-1:0] prefix;
        logic [LOG_WAYS-1:0] dir;
        logic [NW-1:0]       idx;
        r = bits;
        for (int l = 0; l < LOG_WAYS; l++) begin
            prefix = way >> (LOG_WAYS - l);
            dir    = way >> (LOG_WAYS - 1 - l);
            idx    = NW'((1 << l) - 1 + int'(prefix));
            r[idx] = ~dir[0];   // point away from the accessed way
        end
        return r;
    endfunction

    function automatic logic [LOG_WAYS-1:0] walk_tree(input logic [WAYS-2:0] bits);
        int            p;
        logic [NW-1:0] idx;
        p = 0;
        for (int l = 0; l < LOG_WAYS; l++) begin
            idx = NW'((1 << l) - 1 + p);
            p   = 2 * p + int'(bits[idx]);
        end
        return LOG_WAYS'(p);
    endfunction

    assign busy      = (state_q == ST_SWEEP);
    assign sel_ready = !busy;
    assign accept    = sel_valid && sel_ready;
    assign touch_en  = touch_valid && !busy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SWEEP: begin
                if (flush) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_SET) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (flush) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // The victim sees a same-edge touch to its own set.
    always_comb begin
        sel_cur = plru[sel_set];
        if (touch_en && (touch_set == sel_set)) begin
            sel_cur = touch_bits(sel_cur, touch_way);
        end
        inv_found = 1'b0;
        inv_way   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!sel_valids[i]) begin
                inv_found = 1'b1;
                inv_way   = LOG_WAYS'(i);
            end
        end
        victim_way_d = inv_found ? inv_way : walk_tree(sel_cur);
    end

    // When both writes target the same set the auto-touch is issued last and
    // already includes the access touch, so it wins on shared path nodes.
    always_ff @(posedge clk) begin
        if (busy) begin
            plru[cnt_q] <= '0;
        end else begin
            if (touch_en) begin
                plru[touch_set] <= touch_bits(plru[touch_set], touch_way);
            end
            if ((AUTO_TOUCH != 0) && accept) begin
                plru[sel_set] <= touch_bits(sel_cur, victim_way_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            victim_valid       <= 1'b0;
            victim_way         <= '0;
            victim_was_invalid <= 1'b0;
        end else begin
            victim_valid <= accept;
            if (accept) begin
                victim_way         <= victim_way_d;
                victim_was_invalid <= inv_found;
            end
        end
    end

endmodule

// File: tb/tb_plru_replacement_unit.sv
// tb/tb_plru_replacement_unit.sv - randomized and directed check of plru_replacement_unit against a tree model
module tb_plru_replacement_unit;

    localparam int WAYS = 4;
    localparam int LW   = 2;
    localparam int SETS = 8;
    localparam int LS   = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          sel_valid = 1'b0;
    logic [LS-1:0] sel_set = '0;
    logic [3:0]    sel_valids = '0;
    logic          touch_valid = 1'b0;
    logic [LS-1:0] touch_set = '0;
    logic [LW-1:0] touch_way = '0;

    logic          busy_o [2];
    logic          ready_o [2];
    logic          vv_o [2];
    logic [LW-1:0] way_o [2];
    logic          inv_o [2];

    always #5 clk = ~clk;

    plru_replacement_unit #(.WAYS(WAYS), .LOG_WAYS(LW), .SETS(SETS), .LOG_SETS(LS), .AUTO_TOUCH(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .busy(busy_o[0]),
        .sel_valid(sel_valid), .sel_ready(ready_o[0]), .sel_set(sel_set), .sel_valids(sel_valids),
        .victim_valid(vv_o[0]), .victim_way(way_o[0]), .victim_was_invalid(inv_o[0]),
        .touch_valid(touch_valid), .touch_set(touch_set), .touch_way(touch_way));

    plru_replacement_unit #(.WAYS(WAYS), .LOG_WAYS(LW), .SETS(SETS), .LOG_SETS(LS), .AUTO_TOUCH(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .busy(busy_o[1]),
        .sel_valid(sel_valid), .sel_ready(ready_o[1]), .sel_set(sel_set), .sel_valids(sel_valids),
        .victim_valid(vv_o[1]), .victim_way(way_o[1]), .victim_was_invalid(inv_o[1]),
        .touch_valid(touch_valid), .touch_set(touch_set), .touch_way(touch_way));

    // model: index 0 = no auto-touch, 1 = auto-touch
    int  mb [2][SETS][WAYS-1];
    bit  m_sweep = 1'b1;
    int  m_cnt = 0;
    bit  e_vv = 1'b0;
    int  e_way [2];
    bit  e_inv [2];
    bit  chk_en = 1'b0;
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", nm, c, act, exp, $time);
        end
    endtask

    // walk up from the leaf, pointing each parent at the other child
    task automatic m_touch(input int c, input int s, input int w);
        int leaf, p;
        leaf = w + WAYS - 1;
        while (leaf > 0) begin
            p = (leaf - 1) / 2;
            mb[c][s][p] = (leaf == 2 * p + 1) ? 1 : 0;
            leaf = p;
        end
    endtask

    task automatic m_victim(input int c, input int s, input logic [3:0] vals, output int w, output bit inv);
        int n;
        inv = 1'b0;
        w = 0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!vals[i]) begin
                inv = 1'b1;
                w = i;
            end
        end
        if (!inv) begin
            n = 0;
            while (n < WAYS - 1) n = (mb[c][s][n] != 0) ? 2 * n + 2 : 2 * n + 1;
            w = n - (WAYS - 1);
        end
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            m_sweep = 1'b1;
            m_cnt = 0;
            e_vv = 1'b0;
        end else if (m_sweep) begin
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < WAYS - 1; k++) mb[c][m_cnt][k] = 0;
            if (flush) m_cnt = 0;
            else if (m_cnt == SETS - 1) begin
                m_sweep = 1'b0;
                m_cnt = 0;
            end else m_cnt++;
            e_vv = 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (touch_valid) m_touch(c, int'(touch_set), int'(touch_way));
                if (sel_valid) begin
                    m_victim(c, int'(sel_set), sel_valids, e_way[c], e_inv[c]);
                    if (c == 1) m_touch(c, int'(sel_set), e_way[c]);
                end
            end
            e_vv = sel_valid;
            if (flush) begin
                m_sweep = 1'b1;
                m_cnt = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cycle(input bit tv, input int ts, input int tw, input bit sv, input int ss,
                         input logic [3:0] vals, input bit fl);
        touch_valid = tv; touch_set = LS'(ts); touch_way = LW'(tw);
        sel_valid = sv; sel_set = LS'(ss); sel_valids = vals; flush = fl;
        step();
        touch_valid = 1'b0; sel_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 4'hF, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < 2; c++) begin
                chk("busy", c, 32'(busy_o[c]), 32'(m_sweep));
                chk("sel_ready", c, 32'(ready_o[c]), 32'(!m_sweep));
                chk("victim_valid", c, 32'(vv_o[c]), 32'(e_vv));
                if (e_vv) begin
                    chk("victim_way", c, 32'(way_o[c]), 32'(e_way[c]));
                    chk("victim_was_invalid", c, 32'(inv_o[c]), 32'(e_inv[c]));
                end
            end
        end
    end

    initial begin
        int n;
        reset_n = 1'b0;
        idle();
        chk_en = 1'b1;
        idle();
        idle();
        chk("rst_busy", 0, 32'(busy_o[0]), 1);
        chk("rst_vv", 0, 32'(vv_o[0]), 0);
        chk("rst_way", 0, 32'(way_o[0]), 0);
        chk("rst_inv", 0, 32'(inv_o[0]), 0);

        reset_n = 1'b1;
        n = 0;
        while (busy_o[0] && n < 20) begin idle(); n++; end
        chk("busy_cycles_after_reset", 0, n, 8);

        cycle(0, 0, 0, 1, 3, 4'b1111, 0);
        chk("set3_allvalid_way", 0, 32'(way_o[0]), 0);
        chk("set3_allvalid_inv", 0, 32'(inv_o[0]), 0);
        chk("set3_allvalid_vv", 0, 32'(vv_o[0]), 1);
        cycle(0, 0, 0, 1, 3, 4'b1011, 0);
        chk("set3_1011_way", 0, 32'(way_o[0]), 2);
        chk("set3_1011_inv", 0, 32'(inv_o[0]), 1);
        cycle(0, 0, 0, 1, 3, 4'b0000, 0);
        chk("set3_0000_way", 0, 32'(way_o[0]), 0);
        chk("set3_0000_inv", 0, 32'(inv_o[0]), 1);
        idle();
        chk("vv_drops", 0, 32'(vv_o[0]), 0);

        cycle(1, 5, 0, 0, 0, 4'hF, 0);
        cycle(0, 0, 0, 1, 5, 4'hF, 0);
        chk("set5_touch0_way", 0, 32'(way_o[0]), 2);
        cycle(1, 5, 0, 0, 0, 4'hF, 0);
        cycle(1, 5, 2, 0, 0, 4'hF, 0);
        cycle(1, 5, 1, 0, 0, 4'hF, 0);
        cycle(1, 5, 3, 0, 0, 4'hF, 0);
        cycle(0, 0, 0, 1, 5, 4'hF, 0);
        chk("set5_touch0213_way", 0, 32'(way_o[0]), 0);

        cycle(1, 1, 0, 1, 1, 4'hF, 0);
        chk("set1_same_edge_way", 0, 32'(way_o[0]), 2);
        cycle(1, 1, 0, 1, 6, 4'hF, 0);
        chk("set6_other_set_way", 0, 32'(way_o[0]), 0);

        cycle(0, 0, 0, 1, 4, 4'hF, 0);
        chk("auto_first_way", 1, 32'(way_o[1]), 0);
        chk("auto_first_vv", 1, 32'(vv_o[1]), 1);
        cycle(0, 0, 0, 1, 4, 4'hF, 0);
        chk("auto_second_way", 1, 32'(way_o[1]), 2);
        chk("auto_second_vv", 1, 32'(vv_o[1]), 1);
        chk("noauto_second_way", 0, 32'(way_o[0]), 0);

        cycle(1, 2, 0, 0, 0, 4'hF, 0);
        cycle(0, 0, 0, 0, 0, 4'hF, 1);
        chk("flush_busy", 0, 32'(busy_o[0]), 1);
        chk("flush_ready", 0, 32'(ready_o[0]), 0);
        n = 0;
        while (busy_o[0] && n < 20) begin
            cycle(1, 2, 1, 1, 2, 4'hF, 0);
            chk("flush_req_ignored", 0, 32'(vv_o[0]), 0);
            n++;
        end
        chk("busy_cycles_after_flush", 0, n, 8);
        cycle(0, 0, 0, 1, 2, 4'hF, 0);
        chk("set2_after_flush_way", 0, 32'(way_o[0]), 0);

        cycle(0, 0, 0, 0, 0, 4'hF, 1);
        idle();
        idle();
        idle();
        reset_n = 1'b0;
        idle();
        reset_n = 1'b1;
        n = 0;
        while (busy_o[0] && n < 20) begin idle(); n++; end
        chk("busy_cycles_reset_mid_sweep", 0, n, 8);

        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, SETS - 1), $urandom_range(0, WAYS - 1),
                  $urandom_range(0, 2) != 0, $urandom_range(0, SETS - 1),
                  ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15)),
                  $urandom_range(0, 59) == 0);
        end
        reset_n = 1'b1;
        idle();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
